wb_sdrc_arbiter: RTL and testbench
==================================

# wb_sdrc_arbiter

Wishbone arbiter sharing the single Wishbone slave port of `sdrc_top` between up to `NUM_MST` requesters (CPU, DMA, bench masters). Round-robin grant per bus cycle, held until the owner drops `cyc`, with a combinational mux of the owner's signals onto the controller. It sits between the masters and `sdrc_top` in the `wb_clk_i` domain.

## Interface
- `NUM_MST`, 4: number of masters, 2..8.
- `AW`, 26: Wishbone address width, matching the controller's application address.
- `DW`, 32: Wishbone data width. Select width is `DW/8`.
- `TIMEOUT`, 255: watchdog limit in cycles. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `wb_clk_i`  in  1  Wishbone clock.
- `wb_rst_i`  in  1  Synchronous, active-high reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NUM_MST each  Per-master control.
- `m_addr_i`  in  NUM_MST*AW  Packed addresses. Master k occupies `[k*AW +: AW]`.
- `m_dat_i`  in  NUM_MST*DW  Packed write data.
- `m_sel_i`  in  NUM_MST*DW/8  Packed byte selects.
- `m_cti_i`  in  NUM_MST*3  Packed cycle-type identifiers.
- `m_ack_o`  out  NUM_MST  Per-master ack.
- `m_err_o`  out  NUM_MST  Per-master error (timeout).
- `m_dat_o`  out  DW  Read data, broadcast to all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  To `sdrc_top`.
- `s_addr_o`  out  AW  To `sdrc_top`.
- `s_dat_o`  out  DW  To `sdrc_top`.
- `s_sel_o`  out  DW/8  To `sdrc_top`.
- `s_cti_o`  out  3  To `sdrc_top`.
- `s_ack_i`  in  1  From `sdrc_top`.
- `s_dat_i`  in  DW  From `sdrc_top`.
- `grant_o`  out  NUM_MST  One-hot current owner (registered).
- `busy_o`  out  1  High when state is not IDLE.

## Operation
- States:
  - IDLE: no owner.
  - OWN: `grant_o` selects master g.
  - ABORT: only with `WB_ARB_TIMEOUT_EN`.
- IDLE: if any `m_cyc_i` is high, pick the first requester scanning from `rr_ptr` upward with wrap. Register the one-hot grant and go to OWN. Otherwise stay in IDLE.
- OWN, slave drive: `s_*_o` equal master g's inputs. `s_cyc_o = m_cyc_i[g]` and `s_stb_o = m_stb_i[g]`.
- OWN, return path: `m_ack_o[g] = s_ack_i`; all other acks are 0. `m_dat_o = s_dat_i` at all times.
- OWN exit: when `m_cyc_i[g]` is sampled low, clear the grant, set `rr_ptr = (g+1) mod NUM_MST` and return to IDLE.
- Bursts (`cti` 3'b010) keep ownership by construction: ownership is tied to `cyc`, not `cti`.
- IDLE and ABORT outputs: all `s_*_o` are 0.
- Non-owners see ack 0 and wait; there is no back-pressure other than withheld ack.
- A request arriving the same cycle the owner releases is not lost. It is arbitrated in the following IDLE cycle.
- Reset wins over everything. Reset mid-transaction drops `s_cyc_o` in the next cycle with no ack generated.
- Reset values: state IDLE, `grant_o` 0, `rr_ptr` 0, `busy_o` 0, all `m_ack_o`/`m_err_o` 0, all `s_*_o` 0, watchdog 0.

## Timing
- Request to grant: the request is seen in IDLE in cycle N. `grant_o` and `s_cyc_o` are high in N+1.
- Ack path: combinational, zero added latency.
- Release: `m_cyc_i[g]` low in cycle M gives IDLE in M+1. The earliest next grant is M+2, so there is always one dead cycle between owners.
- Back-to-back same master: if it is the only requester it re-wins after the one-cycle gap.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: the watchdog counts OWN cycles with `s_stb_o`=1 and `s_ack_i`=0, and clears on ack.
  - On reaching `TIMEOUT`: pulse `m_err_o[g]` for 1 cycle, drive all `s_*_o` low, and enter ABORT.
  - ABORT waits for `m_cyc_i[g]` low, then advances `rr_ptr` as in a normal release and goes to IDLE.
- Undefined: no counter, no ABORT state, and `m_err_o` is tied to 0.

## Structure
- Package `wb_arb_pkg` holds:
  - state enum (IDLE, OWN, ABORT);
  - CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111);
  - `MAX_MST` = 8.
- One combinational sub-module, `wb_arb_rr_pick`: inputs are the request vector and `rr_ptr`; outputs are the one-hot grant and a valid flag.

## Test plan
- Single master 0 writes `0x0000_0040` = `0xDEADBEEF`, then reads it back: grant one cycle after `cyc`, read data `0xDEADBEEF`, `grant_o` = 4'b0001.
- Masters 0–3 request simultaneously from reset: grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Master 2 holds an 8-beat INCR burst while master 1 requests: master 1 gets no ack until master 2 drops `cyc`, then is granted 2 cycles later.
- `wb_rst_i` asserted mid-burst: the next cycle has `s_cyc_o` = 0, `grant_o` = 0, `rr_ptr` = 0, and no spurious ack.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT`=16, `s_ack_i` forced low: `m_err_o[g]` pulses exactly 16 cycles after `stb`, `s_cyc_o` goes low, ABORT is held until the master drops `cyc`, then the next requester is granted.
- Master 3 releases in the same cycle master 0 raises `cyc`: master 0 is granted after the IDLE cycle, and `rr_ptr` wrapped to 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone SDRAM-controller arbiter.
// Holds the arbiter state enum, Wishbone CTI codes and the master-count limit.
package wb_arb_pkg;

   localparam int MAX_MST = 8;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin picker: first active request at or above ptr_i, with wrap.
// Ports: req_i request vector, ptr_i scan start, gnt_o one-hot pick, vld_o any request.
module wb_arb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [2:0]   ptr_i,
   output logic [N-1:0] gnt_o,
   output logic         vld_o
);

   logic [3:0] sum;

   // Scan offsets from the far end down so the nearest
   // requester to ptr_i is the last (winning) assignment.
   always_comb begin
      gnt_o = '0;
      sum   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, ptr_i} + 4'(i);
         if (sum >= 4'(N)) sum = sum - 4'(N);
         for (int j = 0; j < N; j++) begin
            if (sum == 4'(j) && req_i[j]) begin
               gnt_o    = '0;
               gnt_o[j] = 1'b1;
            end
         end
      end
   end

   assign vld_o = |req_i;

endmodule

// File: rtl/wb_sdrc_arbiter.sv
// Round-robin Wishbone arbiter sharing the sdrc_top slave port among NUM_MST masters.
// Ports: m_* packed master buses, s_* slave bus, grant_o/busy_o status.
// Optional macro WB_ARB_TIMEOUT_EN adds a stall watchdog with ABORT state.
module wb_sdrc_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MST = 4,
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [NUM_MST-1:0]        m_cyc_i,
   input  logic [NUM_MST-1:0]        m_stb_i,
   input  logic [NUM_MST-1:0]        m_we_i,
   input  logic [NUM_MST*AW-1:0]     m_addr_i,
   input  logic [NUM_MST*DW-1:0]     m_dat_i,
   input  logic [NUM_MST*DW/8-1:0]   m_sel_i,
   input  logic [NUM_MST*3-1:0]      m_cti_i,
   output logic [NUM_MST-1:0]        m_ack_o,
   output logic [NUM_MST-1:0]        m_err_o,
   output logic [DW-1:0]             m_dat_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [AW-1:0]             s_addr_o,
   output logic [DW-1:0]             s_dat_o,
   output logic [DW/8-1:0]           s_sel_o,
   output logic [2:0]                s_cti_o,
   input  logic                      s_ack_i,
   input  logic [DW-1:0]             s_dat_i,
   output logic [NUM_MST-1:0]        grant_o,
   output logic                      busy_o
);

   localparam int SW = DW / 8;

   if (NUM_MST < 2 || NUM_MST > MAX_MST || TIMEOUT < 1) begin : g_bad_cfg
      $error("wb_sdrc_arbiter: unsupported NUM_MST or TIMEOUT");
   end

   arb_state_e          state_q;
   logic [NUM_MST-1:0]  grant_q;
   logic [2:0]          rr_ptr_q;
   logic                busy_q;
   logic [NUM_MST-1:0]  pick_gnt;
   logic                pick_vld;
   logic [2:0]          ptr_d;
   logic                own_cyc;
   logic                in_own;

   wb_arb_rr_pick #(.N(NUM_MST)) u_pick (
      .req_i (m_cyc_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .vld_o (pick_vld)
   );

   assign own_cyc = |(m_cyc_i & grant_q);
   assign in_own  = (state_q == ST_OWN);

   // Pointer for the next round: one past the current owner.
   always_comb begin
      ptr_d = '0;
      for (int k = 0; k < NUM_MST; k++) begin
         if (grant_q[k]) ptr_d = (k == NUM_MST - 1) ? 3'd0 : 3'(k + 1);
      end
   end

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_cti_o  = '0;
      if (in_own) begin
         for (int k = 0; k < NUM_MST; k++) begin
            if (grant_q[k]) begin
               s_cyc_o  = m_cyc_i[k];
               s_stb_o  = m_stb_i[k];
               s_we_o   = m_we_i[k];
               s_addr_o = m_addr_i[k*AW +: AW];
               s_dat_o  = m_dat_i[k*DW +: DW];
               s_sel_o  = m_sel_i[k*SW +: SW];
               s_cti_o  = m_cti_i[k*3 +: 3];
            end
         end
      end
   end

   assign m_ack_o = (in_own && s_ack_i) ? grant_q : '0;
   assign m_dat_o = s_dat_i;
   assign grant_o = grant_q;
   assign busy_o  = busy_q;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0]       wdog_q;
   logic [NUM_MST-1:0]  err_q;
   logic                stall;

   assign stall   = s_stb_o & ~s_ack_i;
   assign m_err_o = err_q;
`else
   assign m_err_o = '0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
         wdog_q   <= '0;
         err_q    <= '0;
`endif
      end else begin
`ifdef WB_ARB_TIMEOUT_EN
         err_q <= '0;
`endif
         unique case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant_q <= pick_gnt;
                  state_q <= ST_OWN;
                  busy_q  <= 1'b1;
               end
            end
            ST_OWN: begin
               if (!own_cyc) begin
                  grant_q  <= '0;
                  rr_ptr_q <= ptr_d;
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
                  wdog_q   <= '0;
               end else if (stall) begin
                  // Reaching TIMEOUT stalled cycles aborts the owner.
                  if (wdog_q == WW'(TIMEOUT - 1)) begin
                     err_q   <= grant_q;
                     wdog_q  <= '0;
                     state_q <= ST_ABORT;
                  end else begin
                     wdog_q <= wdog_q + 1'b1;
                  end
               end else begin
                  wdog_q <= '0;
`endif
               end
            end
            ST_ABORT: begin
`ifdef WB_ARB_TIMEOUT_EN
               if (!own_cyc) begin
                  grant_q  <= '0;
                  rr_ptr_q <= ptr_d;
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
               end
`endif
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Scoreboard bench for wb_sdrc_arbiter: directed master transfers against a zero-wait slave.
// Expected acks and grants are queued by stimulus and popped by an independent monitor.
module tb_wb_sdrc_arbiter;
   import wb_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 26;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
   logic [N*AW-1:0] m_addr = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [N*4-1:0]  m_sel = '0;
   logic [N*3-1:0]  m_cti = '0;
   logic [N-1:0]    m_ack, m_err, grant;
   logic [DW-1:0]   m_dat_o, s_dat_o, s_dat_i;
   logic            s_cyc, s_stb, s_we, s_ack, busy;
   logic [AW-1:0]   s_addr;
   logic [3:0]      s_sel;
   logic [2:0]      s_cti;

   logic            ack_en = 1'b1;
   logic [31:0]     mem [64];

   int vectors = 0;
   int miscompares = 0;

   typedef struct { int m; bit we; logic [31:0] d; } ack_t;
   typedef struct { int m; int gap; } gnt_t;
   ack_t aq[$];
   gnt_t gq[$];

   always #5 clk = ~clk;

   wb_sdrc_arbiter #(.NUM_MST(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .wb_clk_i (clk),     .wb_rst_i (rst),
      .m_cyc_i  (m_cyc),   .m_stb_i  (m_stb),  .m_we_i (m_we),
      .m_addr_i (m_addr),  .m_dat_i  (m_dat),
      .m_sel_i  (m_sel),   .m_cti_i  (m_cti),
      .m_ack_o  (m_ack),   .m_err_o  (m_err),  .m_dat_o (m_dat_o),
      .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),  .s_we_o (s_we),
      .s_addr_o (s_addr),  .s_dat_o  (s_dat_o),
      .s_sel_o  (s_sel),   .s_cti_o  (s_cti),
      .s_ack_i  (s_ack),   .s_dat_i  (s_dat_i),
      .grant_o  (grant),   .busy_o   (busy)
   );

   // Zero-wait slave memory
   assign s_ack   = s_cyc & s_stb & ack_en;
   assign s_dat_i = mem[s_addr[7:2]];
   always @(posedge clk) if (s_ack && s_we) mem[s_addr[7:2]] <= s_dat_o;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic exp_ack(input int m, input bit we, input logic [31:0] d);
      aq.push_back('{m: m, we: we, d: d});
   endtask

   task automatic exp_gnt(input int m, input int gap);
      gq.push_back('{m: m, gap: gap});
   endtask

   // Monitor: pops expectations whenever the DUT acks or grants.
   logic [N-1:0] prev_g = '0;
   int           idle_n = 0;
   ack_t         ae;
   gnt_t         ge;
   always @(negedge clk) begin
      #2;
      for (int k = 0; k < N; k++) begin
         if (m_ack[k]) begin
            if (aq.size() == 0) chk("ack_unexpected", 64'(m_ack), 64'd0);
            else begin
               ae = aq.pop_front();
               chk("ack_owner", 64'(k), 64'(ae.m));
               if (!ae.we) chk("ack_rdata", 64'(m_dat_o), 64'(ae.d));
            end
         end
      end
      if (grant != '0 && grant != prev_g) begin
         if (gq.size() == 0) chk("grant_unexpected", 64'(grant), 64'd0);
         else begin
            ge = gq.pop_front();
            chk("grant_onehot", 64'(grant), 64'(1) << ge.m);
            if (ge.gap >= 0) chk("grant_gap", 64'(idle_n), 64'(ge.gap));
         end
         idle_n = 0;
      end else if (grant == '0) begin
         idle_n++;
      end
      prev_g = grant;
   end

   // Master transfer, entered at a negedge; leaves at the negedge where cyc drops.
   task automatic xfer(input int k, input bit we, input logic [25:0] a,
                       input logic [31:0] d, input int beats,
                       output int lat, output logic [31:0] rd);
      int  n;
      bit  got;
      lat = -1;
      rd  = '0;
      n   = 0;
      m_we[k] = we;
      m_sel[k*4 +: 4] = 4'hF;
      for (int b = 0; b < beats; b++) begin
         m_addr[k*AW +: AW] = a + 26'(4 * b);
         m_dat[k*DW +: DW]  = d + 32'(b);
         m_cti[k*3 +: 3] = (beats == 1) ? CTI_CLASSIC :
                           (b == beats - 1) ? CTI_EOB : CTI_INCR;
         m_cyc[k] = 1'b1;
         m_stb[k] = 1'b1;
         #1;
         got = m_ack[k];
         while (!got && n < 64) begin
            @(negedge clk);
            #1;
            n++;
            if (grant[k] && lat < 0) lat = n;
            got = m_ack[k];
         end
         if (!got) begin
            chk("xfer_timeout", 64'(k), 64'hFFFF);
            break;
         end
         if (!we) rd = m_dat_o;
         @(negedge clk);
      end
      m_cyc[k] = 1'b0;
      m_stb[k] = 1'b0;
      m_we[k]  = 1'b0;
      m_cti[k*3 +: 3] = CTI_CLASSIC;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          l, n;
      logic [31:0] r;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_s_cyc", 64'(s_cyc), 64'd0);
      chk("rst_s_stb", 64'(s_stb), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_m_ack", 64'(m_ack), 64'd0);
      chk("rst_m_err", 64'(m_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single master write then read-back
      exp_gnt(0, -1);
      exp_ack(0, 1'b1, 32'h0);
      xfer(0, 1'b1, 26'h40, 32'hDEADBEEF, 1, l, r);
      chk("t1_grant_lat", 64'(l), 64'd1);
      @(negedge clk);
      exp_gnt(0, 1);
      exp_ack(0, 1'b0, 32'hDEADBEEF);
      xfer(0, 1'b0, 26'h40, 32'h0, 1, l, r);
      chk("t1_rdata", 64'(r), 64'hDEADBEEF);
      chk("t1_regrant_lat", 64'(l), 64'd1);

      // Four simultaneous requesters from reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_gnt(0, -1); exp_gnt(1, 1); exp_gnt(2, 1); exp_gnt(3, 1); exp_gnt(0, 1);
      exp_ack(0, 1'b1, 32'h0);
      exp_ack(1, 1'b1, 32'h0);
      exp_ack(2, 1'b1, 32'h0);
      exp_ack(3, 1'b1, 32'h0);
      exp_ack(0, 1'b0, 32'hDEADBEEF);
      fork
         begin
            int l0; logic [31:0] r0;
            xfer(0, 1'b1, 26'h80, 32'h1000_0000, 1, l0, r0);
            @(negedge clk);
            xfer(0, 1'b0, 26'h40, 32'h0, 1, l0, r0);
            chk("t2_m0_rdata", 64'(r0), 64'hDEADBEEF);
         end
         begin
            int l1; logic [31:0] r1;
            xfer(1, 1'b1, 26'h84, 32'h1000_0001, 1, l1, r1);
         end
         begin
            int l2; logic [31:0] r2;
            xfer(2, 1'b1, 26'h88, 32'h1000_0002, 1, l2, r2);
         end
         begin
            int l3; logic [31:0] r3;
            xfer(3, 1'b1, 26'h8C, 32'h1000_0003, 1, l3, r3);
         end
      join

      // Master 2 INCR burst blocks master 1
      @(negedge clk);
      exp_gnt(2, -1); exp_gnt(1, 1);
      for (int b = 0; b < 8; b++) exp_ack(2, 1'b1, 32'h0);
      exp_ack(1, 1'b0, 32'hB000_0001);
      fork
         begin
            int l2; logic [31:0] r2;
            xfer(2, 1'b1, 26'hC0, 32'hB000_0000, 8, l2, r2);
         end
         begin
            int l1; logic [31:0] r1;
            @(negedge clk);
            xfer(1, 1'b0, 26'hC4, 32'h0, 1, l1, r1);
            chk("t3_m1_rdata", 64'(r1), 64'hB000_0001);
            chk("t3_m1_wait", 64'(l1), 64'd10);
         end
      join

      // Reset in the middle of a burst
      @(negedge clk);
      exp_gnt(2, -1);
      for (int b = 0; b < 3; b++) exp_ack(2, 1'b1, 32'h0);
      m_addr[2*AW +: AW] = 26'h20;
      m_dat[2*DW +: DW]  = 32'h2222_2222;
      m_sel[8 +: 4] = 4'hF;
      m_cti[6 +: 3] = CTI_INCR;
      m_we[2]  = 1'b1;
      m_cyc[2] = 1'b1;
      m_stb[2] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!grant[2] && n < 20);
      chk("t4_grant_seen", 64'(grant), 64'b0100);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("t4_s_cyc", 64'(s_cyc), 64'd0);
      chk("t4_grant", 64'(grant), 64'd0);
      chk("t4_m_ack", 64'(m_ack), 64'd0);
      chk("t4_busy",  64'(busy),  64'd0);
      rst = 1'b0;
      m_cyc[2] = 1'b0;
      m_stb[2] = 1'b0;
      m_we[2]  = 1'b0;
      m_cti[6 +: 3] = CTI_CLASSIC;
      @(negedge clk);
      exp_gnt(1, -1); exp_gnt(3, 1);
      exp_ack(1, 1'b0, 32'hB000_0002);
      exp_ack(3, 1'b0, 32'h1000_0001);
      fork
         begin
            int l1; logic [31:0] r1;
            xfer(1, 1'b0, 26'hC8, 32'h0, 1, l1, r1);
         end
         begin
            int l3; logic [31:0] r3;
            xfer(3, 1'b0, 26'h84, 32'h0, 1, l3, r3);
         end
      join

      // Master 3 releases as masters 0 and 1 raise cyc
      @(negedge clk);
      exp_gnt(3, -1); exp_gnt(0, 1); exp_gnt(1, 1);
      exp_ack(3, 1'b1, 32'h0);
      exp_ack(0, 1'b0, 32'h3333_3333);
      exp_ack(1, 1'b1, 32'h0);
      fork
         begin
            int l3; logic [31:0] r3;
            xfer(3, 1'b1, 26'h90, 32'h3333_3333, 1, l3, r3);
         end
         begin
            int w;
            w = 0;
            do begin
               @(negedge clk);
               #1;
               w++;
            end while (!m_ack[3] && w < 20);
            @(negedge clk);
            fork
               begin
                  int l0; logic [31:0] r0;
                  xfer(0, 1'b0, 26'h90, 32'h0, 1, l0, r0);
                  chk("t5_m0_rdata", 64'(r0), 64'h3333_3333);
                  chk("t5_m0_lat", 64'(l0), 64'd2);
               end
               begin
                  int l1; logic [31:0] r1;
                  xfer(1, 1'b1, 26'h94, 32'h1111_1111, 1, l1, r1);
               end
            join
         end
      join

`ifdef WB_ARB_TIMEOUT_EN
      // Stalled slave: watchdog aborts the owner
      @(negedge clk);
      ack_en = 1'b0;
      exp_gnt(1, -1);
      m_addr[1*AW +: AW] = 26'h0;
      m_sel[4 +: 4] = 4'hF;
      m_cyc[1] = 1'b1;
      m_stb[1] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!grant[1] && n < 20);
      n = 0;
      while (!m_err[1] && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("t6_err_cycle", 64'(n), 64'd16);
      chk("t6_err_vec", 64'(m_err), 64'b0010);
      chk("t6_s_cyc", 64'(s_cyc), 64'd0);
      chk("t6_busy", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      chk("t6_err_pulse", 64'(m_err), 64'd0);
      ack_en = 1'b1;
      exp_gnt(2, -1);
      exp_ack(2, 1'b0, 32'h3333_3333);
      @(negedge clk);
      fork
         begin
            int l2; logic [31:0] r2;
            xfer(2, 1'b0, 26'h90, 32'h0, 1, l2, r2);
            chk("t6_m2_rdata", 64'(r2), 64'h3333_3333);
         end
         begin
            repeat (3) begin
               @(negedge clk);
               #1;
               chk("t6_abort_s_cyc", 64'(s_cyc), 64'd0);
               chk("t6_abort_grant", 64'(grant), 64'b0010);
            end
            m_cyc[1] = 1'b0;
            m_stb[1] = 1'b0;
         end
      join
`endif

      repeat (3) @(negedge clk);
      #3;
      chk("sb_ack_empty", 64'(aq.size()), 64'd0);
      chk("sb_gnt_empty", 64'(gq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
